// File: rtl/ysyx_24110015_axi4_burst_mem.sv
// ysyx_24110015_axi4_burst_mem
// AXI4 slave backed by a DEPTH x DATA_W word memory. It serves one transaction
// at a time, either a read burst or a write burst. It supports FIXED and INCR
// bursts. WRAP and the reserved burst type are answered with SLVERR, and beats
// outside the memory window are answered with DECERR.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ar* / arready                 read address channel
//   r* / rready                   read data channel
//   aw* / awready                 write address channel
//   w* / wready                   write data channel
//   b* / bready                   write response channel
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; accepts AR (preferred) or AW
// RD_WAIT | latency down-counter running before the next read beat
// RD_DATA | read beat presented, holding until rready
// WR_DATA | accepting W beats of the current write burst
// WR_RESP | write response presented, holding until bready
module ysyx_24110015_axi4_burst_mem #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 32,
    parameter int                ID_W   = 4,
    parameter int                DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter int                RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT    = {1'b0, BASE} + (ADDR_W+1)'(DEPTH * BYTES);
    localparam logic [7:0]      LAT_INIT = 8'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_q;
    logic [7:0]        lat_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic [1:0]        bresp_q;
    logic              derr_q;

    logic [ADDR_W-1:0] beat_addr;
    logic [IDX_W-1:0]  idx;
    logic              in_range, burst_bad, last_beat;
    logic              ar_hs, aw_hs, w_hs, r_hs, b_hs, w_end, w_slv, mem_we;

    assign beat_addr = (burst_q == 2'b00) ? addr_q : addr_q + (ADDR_W'(beat_q) << OFF_W);
    assign in_range  = ({1'b0, beat_addr} >= {1'b0, BASE}) && ({1'b0, beat_addr} < LIMIT);
    assign idx       = IDX_W'((beat_addr - BASE) >> OFF_W);
    assign burst_bad = burst_q[1];
    assign last_beat = (beat_q == len_q);

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign r_hs  = rvalid && rready;
    assign b_hs  = bvalid && bready;
    // A burst ends on wlast or on its final beat, whichever comes first. A
    // disagreement between the two is a protocol error.
    assign w_end  = wlast || last_beat;
    assign w_slv  = burst_bad || (wlast != last_beat);
    assign mem_we = w_hs && in_range && !burst_bad;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ar_hs) state_nx = RD_WAIT;
                     else if (aw_hs) state_nx = WR_DATA;
            RD_WAIT: if (lat_q == 8'd0) state_nx = RD_DATA;
            RD_DATA: if (r_hs) state_nx = rlast_q ? IDLE : RD_WAIT;
            WR_DATA: if (w_hs && w_end) state_nx = WR_RESP;
            WR_RESP: if (b_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        bvalid  = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        bid     = '0;
        bresp   = 2'b00;
        if (!rst) begin
            arready = (state == IDLE);
            awready = (state == IDLE) && !arvalid;
            wready  = (state == WR_DATA);
            rvalid  = (state == RD_DATA);
            bvalid  = (state == WR_RESP);
            rid     = id_q;
            rdata   = rdata_q;
            rresp   = rresp_q;
            rlast   = rlast_q;
            bid     = id_q;
            bresp   = bresp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= 2'b00;
            beat_q  <= '0;
            lat_q   <= '0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
            rlast_q <= 1'b0;
            bresp_q <= 2'b00;
            derr_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        id_q    <= arid;
                        addr_q  <= araddr;
                        len_q   <= arlen;
                        burst_q <= arburst;
                        beat_q  <= '0;
                        lat_q   <= LAT_INIT;
                    end else if (aw_hs) begin
                        id_q    <= awid;
                        addr_q  <= awaddr;
                        len_q   <= awlen;
                        burst_q <= awburst;
                        beat_q  <= '0;
                        derr_q  <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (lat_q != 8'd0) begin
                        lat_q <= lat_q - 8'd1;
                    end else begin
                        // Capture the beat so it stays stable while rready is low.
                        rlast_q <= last_beat;
                        if (burst_bad) begin
                            rresp_q <= 2'b10;
                            rdata_q <= '0;
                        end else if (!in_range) begin
                            rresp_q <= 2'b11;
                            rdata_q <= '0;
                        end else begin
                            rresp_q <= 2'b00;
                            rdata_q <= mem[idx];
                        end
                    end
                end
                RD_DATA: begin
                    if (r_hs && !rlast_q) begin
                        beat_q <= beat_q + 8'd1;
                        lat_q  <= LAT_INIT;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 8'd1;
                        if (!in_range) derr_q <= 1'b1;
                        if (w_end) begin
                            if (w_slv)                      bresp_q <= 2'b10;
                            else if (derr_q || !in_range)   bresp_q <= 2'b11;
                            else                            bresp_q <= 2'b00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_axi4_burst_mem.sv
module tb_ysyx_24110015_axi4_burst_mem;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  arid = '0, awid = '0, rid, bid;
    logic [31:0] araddr = '0, awaddr = '0, rdata, wdata = '0;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
    logic        arvalid = 0, arready, rlast, rvalid, rready = 1;
    logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1;

    always #5 clk = ~clk;

    ysyx_24110015_axi4_burst_mem #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t r_q[$];
    b_exp_t b_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int rready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timeout, event not seen, expected within bound", name);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rready_mode)
            0:       rready = 1'b1;
            1:       rready = ~rready;
            default: rready = 1'b0;
        endcase
    end

    // Monitor: pops expected beats/responses on each handshake and checks
    // that a stalled R beat holds its value.
    initial begin
        logic   hold_p;
        r_exp_t hold_v;
        r_exp_t e;
        b_exp_t be;
        hold_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_p = 1'b0;
            end else begin
                if (hold_p) begin
                    check("r_hold_valid", rvalid, 1);
                    check("r_hold_beat", {rid, rdata, rresp, rlast}, hold_v);
                end
                hold_p = 1'b0;
                if (rvalid && rready) begin
                    if (r_q.size() == 0) begin
                        timeout("r_unexpected_beat");
                    end else begin
                        e = r_q.pop_front();
                        check("r_id", rid, e.id);
                        check("r_data", rdata, e.data);
                        check("r_resp", rresp, e.resp);
                        check("r_last", rlast, e.last);
                    end
                end else if (rvalid) begin
                    hold_p = 1'b1;
                    hold_v = {rid, rdata, rresp, rlast};
                end
                if (bvalid && bready) begin
                    if (b_q.size() == 0) begin
                        timeout("b_unexpected_resp");
                    end else begin
                        be = b_q.pop_front();
                        check("b_id", bid, be.id);
                        check("b_resp", bresp, be.resp);
                    end
                end
            end
        end
    end

    function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic wait_hs(input int sel, input string name);
        int  n;
        logic ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            case (sel)
                0:       ok = arready;
                1:       ok = awready;
                default: ok = wready;
            endcase
            n++;
        end
        if (!ok) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (r_q.size() != 0 || b_q.size() != 0) begin
            timeout(name);
            r_q.delete();
            b_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        wait_hs(0, "ar_handshake");
        arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [127:0] d, input logic [7:0] rs);
        int n;
        for (int i = 0; i <= int'(len); i++)
            r_q.push_back({id, d[i*32 +: 32], rs[i*2 +: 2], (i == int'(len))});
        issue_ar(id, addr, len, burst);
        n = 0;
        while (!rvalid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rd_latency", n, RD_LAT);
        wait_drained("read_drain");
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nb, input int wl_idx,
                            input logic [127:0] d, input logic [15:0] s, input logic [1:0] exp);
        b_q.push_back({id, exp});
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        wait_hs(1, "aw_handshake");
        awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            wdata = d[i*32 +: 32];
            wstrb = s[i*4 +: 4];
            wlast = (i == wl_idx);
            wvalid = 1'b1;
            wait_hs(2, "w_handshake");
            wvalid = 1'b0;
            wlast = 1'b0;
        end
        wait_drained("write_drain");
    endtask

    initial begin
        int n;
        // Reset state: awvalid high so an ungated ready would show.
        awvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_r_fields", {rid, rdata, rresp, rlast}, 0);
        check("rst_b_fields", {bid, bresp}, 0);
        awvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write then read.
        do_write(4'd1, 32'h8000_0010, 8'd0, 2'b01, 1, 0, pk(32'hDEADBEEF, 0, 0, 0), 16'hFFFF, 2'b00);
        do_read(4'd2, 32'h8000_0010, 8'd0, 2'b01, pk(32'hDEADBEEF, 0, 0, 0), 8'h00);

        // INCR burst, read back with rready toggling, then a FIXED read.
        do_write(4'd3, 32'h8000_0100, 8'd3, 2'b01, 4, 3, pk(1, 2, 3, 4), 16'hFFFF, 2'b00);
        rready_mode = 1;
        do_read(4'd4, 32'h8000_0100, 8'd3, 2'b01, pk(1, 2, 3, 4), 8'h00);
        rready_mode = 0;
        do_read(4'd5, 32'h8000_0100, 8'd2, 2'b00, pk(1, 1, 1, 0), 8'h00);

        // Partial strobe.
        do_write(4'd6, 32'h8000_0200, 8'd0, 2'b01, 1, 0, pk(32'h11223344, 0, 0, 0), 16'hFFFF, 2'b00);
        do_write(4'd7, 32'h8000_0200, 8'd0, 2'b01, 1, 0, pk(32'hAABBCCDD, 0, 0, 0), 16'h0005, 2'b00);
        do_read(4'd8, 32'h8000_0200, 8'd0, 2'b01, pk(32'h11BB33DD, 0, 0, 0), 8'h00);

        // Read below BASE.
        do_read(4'd9, 32'h7FFF_FFFC, 8'd0, 2'b01, pk(0, 0, 0, 0), 8'h03);

        // Early wlast: only beats 0-1 land.
        do_write(4'd1, 32'h8000_0300, 8'd3, 2'b01, 4, 3, pk(5, 6, 7, 8), 16'hFFFF, 2'b00);
        do_write(4'd2, 32'h8000_0300, 8'd3, 2'b01, 2, 1, pk(32'hA0, 32'hA1, 0, 0), 16'hFFFF, 2'b10);
        do_read(4'd3, 32'h8000_0300, 8'd3, 2'b01, pk(32'hA0, 32'hA1, 7, 8), 8'h00);

        // WRAP write leaves memory alone; WRAP read gives SLVERR on every beat.
        do_write(4'd4, 32'h8000_0300, 8'd0, 2'b10, 1, 0, pk(32'hFFFFFFFF, 0, 0, 0), 16'hFFFF, 2'b10);
        do_read(4'd5, 32'h8000_0300, 8'd0, 2'b01, pk(32'hA0, 0, 0, 0), 8'h00);
        do_read(4'd6, 32'h8000_0300, 8'd1, 2'b10, pk(0, 0, 0, 0), 8'h0A);

        // Final beat without wlast: SLVERR, beats still stored.
        do_write(4'd7, 32'h8000_0500, 8'd1, 2'b01, 2, -1, pk(32'h55, 32'h66, 0, 0), 16'hFFFF, 2'b10);
        do_read(4'd8, 32'h8000_0500, 8'd1, 2'b01, pk(32'h55, 32'h66, 0, 0), 8'h00);

        // Burst crossing the top of the window.
        do_write(4'd9, 32'h8000_0FFC, 8'd1, 2'b01, 2, 1, pk(32'hCAFEF00D, 32'h0BADBEEF, 0, 0), 16'hFFFF, 2'b11);
        do_read(4'd10, 32'h8000_0FFC, 8'd1, 2'b01, pk(32'hCAFEF00D, 0, 0, 0), 8'h0C);

        // Simultaneous AR/AW: read first; early W stalls.
        r_q.push_back({4'd11, 32'hDEADBEEF, 2'b00, 1'b1});
        b_q.push_back({4'd12, 2'b00});
        arid = 4'd11; araddr = 32'h8000_0010; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'd12; awaddr = 32'h8000_0400; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        wdata = 32'h12345678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("arb_arready", arready, 1);
        check("arb_awready", awready, 0);
        check("arb_wready_stall", wready, 0);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        wait_hs(1, "arb_aw_handshake");
        awvalid = 1'b0;
        wait_hs(2, "arb_w_handshake");
        wvalid = 1'b0;
        wlast = 1'b0;
        wait_drained("arb_drain");
        do_read(4'd13, 32'h8000_0400, 8'd0, 2'b01, pk(32'h12345678, 0, 0, 0), 8'h00);

        // Reset in the middle of a stalled read burst.
        rready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        issue_ar(4'd14, 32'h8000_0100, 8'd3, 2'b01);
        n = 0;
        while (!rvalid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rvalid) timeout("rst_burst_rvalid");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rvalid", rvalid, 0);
        check("midrst_arready", arready, 0);
        rst = 1'b0;
        rready_mode = 0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid || bvalid) n++;
        end
        check("postrst_no_beats", n, 0);
        @(posedge clk);
        #1;
        do_read(4'd15, 32'h8000_0010, 8'd0, 2'b01, pk(32'hDEADBEEF, 0, 0, 0), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_24110015_axi4_burst_mem.md
YSYX_24110015_AXI4_BURST_MEM -- requirements
Module: ysyx_24110015_axi4_burst_mem

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  DATA_W, 32, data bus width in bits (32 or 64).
  ADDR_W, 32, address width.
  ID_W, 4, transaction ID width.
  DEPTH, 1024, memory size in words.
  BASE, 32'h8000_0000, byte address of word 0.
  RD_LAT, 1, read latency per beat in cycles (>=1).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk, in, 1, sole clock.
  rst, in, 1, synchronous active-high reset.
  arid/araddr/arlen/arburst/arvalid, in, ID_W/ADDR_W/8/2/1, read address channel.
  arready, out, 1, read address accepted.
  rid/rdata/rresp/rlast/rvalid, out, ID_W/DATA_W/2/1/1, read data channel.
  rready, in, 1, read data accepted.
  awid/awaddr/awlen/awburst/awvalid, in, ID_W/ADDR_W/8/2/1, write address channel.
  awready, out, 1, write address accepted.
  wdata/wstrb/wlast/wvalid, in, DATA_W/DATA_W/8/1/1, write data channel.
  wready, out, 1, write data accepted.
  bid/bresp/bvalid, out, ID_W/2/1, write response channel.
  bready, in, 1, write response accepted.
REQ-003 One clock domain and synchronous active-high reset SHALL apply, with all state updated only on the rising edge of clk.

Function
REQ-004 The block SHALL hold DEPTH words of DATA_W bits internally, with one outstanding transaction (read or write) at a time.
REQ-005 The FSM states SHALL be IDLE, RD_WAIT, RD_DATA, WR_DATA and WR_RESP.
REQ-006 arready SHALL be 1 only in IDLE, and awready SHALL be 1 only in IDLE when arvalid=0, so reads win a simultaneous arvalid/awvalid.
REQ-007 wready SHALL be 1 only in WR_DATA, so W beats presented before the AW handshake stall.
REQ-008 On the AR handshake, the block SHALL latch id, addr, len and burst and go to RD_WAIT with a counter loaded to RD_LAT-1, moving to RD_DATA when the counter is 0.
REQ-009 In RD_DATA, rvalid SHALL be 1 and rdata/rresp/rid/rlast SHALL stay stable until rready=1.
REQ-010 rlast SHALL be 1 on beat arlen, since the burst is arlen+1 beats.
REQ-011 After a non-last R handshake the block SHALL return to RD_WAIT, so each beat appears RD_LAT cycles after the previous handshake (or after the AR handshake for beat 0); after the last beat it SHALL return to IDLE.
REQ-012 Beat address SHALL be addr + beat*(DATA_W/8) for INCR and addr for FIXED, with the word index taken as (beat address - BASE) >> log2(DATA_W/8).
REQ-013 A beat whose address is below BASE or at/above BASE+DEPTH*DATA_W/8 SHALL give DECERR (2'b11) with rdata=0 on reads and SHALL be ignored on writes.
REQ-014 burst=WRAP or 2'b11 SHALL give SLVERR (2'b10) on every read beat and on the write response, with no memory write.
REQ-015 On the AW handshake the block SHALL latch the address fields and go to WR_DATA.
REQ-016 Each W handshake SHALL update the selected word at that edge, only the bytes whose wstrb bit is 1.
REQ-017 Write termination SHALL be:
  wlast on a beat before awlen: end the burst, response SLVERR.
  Beat awlen without wlast: end the burst, response SLVERR.
  Otherwise: response DECERR if any beat was out of range, else OKAY (2'b00).
  SLVERR SHALL take priority over DECERR.
REQ-018 bvalid SHALL rise the cycle after the terminating W beat, and bid/bresp SHALL stay stable until bready=1, then the FSM SHALL return to IDLE.
REQ-019 A read beat SHALL return data written by any earlier completed write.

Reset
REQ-020 When rst=1 at a rising edge, state SHALL go to IDLE and the beat/latency counters SHALL clear.
REQ-021 During reset, rvalid, bvalid, rlast, rdata, rresp, rid, bresp and bid SHALL be 0.
REQ-022 During reset, arready, awready and wready SHALL be 0 while rst=1.
REQ-023 Reset SHALL abort any burst in progress with no further beats or response.
REQ-024 Memory contents SHALL be unaffected by reset.

Verification
REQ-025 Single write then read: AW 0x8000_0010 len=0 INCR, W 0xDEADBEEF strb=F wlast=1 -> bresp=00; AR same address -> rdata=0xDEADBEEF, rlast=1, rvalid RD_LAT cycles after the AR handshake.
REQ-026 INCR burst: write len=3 at 0x8000_0100 with data 1..4 and strb=F, then read it back with rready toggling 1/0 -> four beats 1,2,3,4, data held while stalled, rlast only on beat 3.
REQ-027 Partial strobe: word 0x11223344 then write 0xAABBCCDD strb=4'b0101 -> read gives 0x11BB33DD.
REQ-028 Errors: read 0x7FFF_FFFC -> rresp=11, rdata=0; write len=3 with wlast on beat 1 -> bresp=10 and only beats 0-1 written; awburst=WRAP -> bresp=10 and memory unchanged.
REQ-029 Arbitration and reset: arvalid and awvalid asserted the same cycle -> AR accepted first; rst=1 mid read burst -> rvalid=0 next cycle, and the next AR is served normally.
